// File: rtl/stroke_painter.sv
// Canvas paint stage: reads each pixel's canvas word, tests it against a square pen
// brush latched once per frame, and writes either the pen colour or the live camera pixel.
module stroke_painter #(
  parameter int unsigned H_PIXELS     = 320,
  parameter int unsigned V_PIXELS     = 240,
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned BRAM_LAT     = 2,
  parameter int unsigned MAX_RADIUS   = 3,
  parameter int unsigned STALE_FRAMES = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [10:0]       x_com_in,
  input  logic [9:0]        y_com_in,
  input  logic              com_valid_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              pixel_valid_in,
  input  logic [PIX_W-3:0]  camera_pixel_in,
  input  logic [1:0]        color_select_in,
  input  logic [1:0]        mode_in,
  input  logic [1:0]        brush_size_in,
  input  logic [PIX_W-1:0]  pixel_from_bram_in,
  output logic [ADDR_W-1:0] pixel_addr_bram_check_out,
  output logic [PIX_W-1:0]  pixel_out_forbram,
  output logic [ADDR_W-1:0] pixel_addr_forbram,
  output logic              valid_pixel_forbram,
  output logic              pen_down_out
);

  localparam int unsigned CAM_W   = PIX_W - 2;
  localparam int unsigned DW      = 12;
  localparam int unsigned STALE_W = $clog2(STALE_FRAMES + 1);
  localparam int unsigned AQ_W    = BRAM_LAT * ADDR_W;
  localparam int unsigned CQ_W    = BRAM_LAT * CAM_W;

  localparam logic [1:0] MODE_WRITE = 2'b00;
  localparam logic [1:0] MODE_ERASE = 2'b01;
  localparam logic [1:0] MODE_CLEAR = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, LIFTED = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [10:0]        pend_x_q, act_x_q, eff_x_c;
  logic [9:0]         pend_y_q, act_y_q, eff_y_c;
  logic [1:0]         pend_r_q, act_r_q, eff_r_c, brush_r_c;
  logic               pend_flag_q;
  logic [STALE_W-1:0] stale_q, stale_d;
  logic               frame_start_c, load_active_c, pen_eff_c;

  assign frame_start_c = pixel_valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign brush_r_c     = (32'(brush_size_in) > MAX_RADIUS) ? 2'(MAX_RADIUS) : brush_size_in;

  // Frame-start bookkeeping: promote pending COM or age the stale counter
  always_comb begin
    state_d       = state_q;
    stale_d       = stale_q;
    load_active_c = 1'b0;
    if (frame_start_c) begin
      if (pend_flag_q) begin
        load_active_c = 1'b1;
        stale_d       = '0;
        state_d       = TRACK;
      end else begin
        if (stale_q < STALE_W'(STALE_FRAMES)) stale_d = stale_q + STALE_W'(1);
        if ((stale_d == STALE_W'(STALE_FRAMES)) && (state_q == TRACK)) state_d = LIFTED;
      end
    end
  end

  // The frame-start pixel itself already sees the brush that is being loaded
  assign pen_eff_c = (state_d == TRACK);
  assign eff_x_c   = load_active_c ? pend_x_q : act_x_q;
  assign eff_y_c   = load_active_c ? pend_y_q : act_y_q;
  assign eff_r_c   = load_active_c ? pend_r_q : act_r_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      stale_q      <= STALE_W'(STALE_FRAMES);
      pen_down_out <= 1'b0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      pend_r_q     <= '0;
      pend_flag_q  <= 1'b0;
      act_x_q      <= '0;
      act_y_q      <= '0;
      act_r_q      <= '0;
    end else begin
      state_q      <= state_d;
      stale_q      <= stale_d;
      pen_down_out <= (state_d == TRACK);
      if (load_active_c) begin
        act_x_q <= pend_x_q;
        act_y_q <= pend_y_q;
        act_r_q <= pend_r_q;
      end
      if (com_valid_in) begin
        pend_x_q    <= x_com_in;
        pend_y_q    <= y_com_in;
        pend_r_q    <= brush_r_c;
        pend_flag_q <= 1'b1;
      end else if (load_active_c) begin
        pend_flag_q <= 1'b0;
      end
    end
  end

  // Stage 0: bounds check, linear address and brush hit test
  logic [DW-1:0]     h_w, v_w, x_w, y_w, dx_c, dy_c;
  logic              hit_c, in_bounds_c, s0_vld_c;
  logic [ADDR_W-1:0] addr_c;

  assign h_w         = DW'(hcount_in);
  assign v_w         = DW'(vcount_in);
  assign x_w         = DW'(eff_x_c);
  assign y_w         = DW'(eff_y_c);
  assign dx_c        = (h_w >= x_w) ? (h_w - x_w) : (x_w - h_w);
  assign dy_c        = (v_w >= y_w) ? (v_w - y_w) : (y_w - v_w);
  assign hit_c       = pen_eff_c && (dx_c <= DW'(eff_r_c)) && (dy_c <= DW'(eff_r_c));
  assign in_bounds_c = (32'(hcount_in) < H_PIXELS) && (32'(vcount_in) < V_PIXELS);
  assign addr_c      = ADDR_W'(32'(vcount_in) * H_PIXELS + 32'(hcount_in));
  assign s0_vld_c    = pixel_valid_in && in_bounds_c;

  // Delay line: entry 0 is stage 0, the top entry lines up with pixel_from_bram_in
  logic [BRAM_LAT-1:0][ADDR_W-1:0] addr_q;
  logic [BRAM_LAT-1:0][CAM_W-1:0]  cam_q;
  logic [BRAM_LAT-1:0]             hit_q, vld_q;
  logic [ADDR_W-1:0]               addr_in_c;
  logic [CAM_W-1:0]                cam_in_c;

  assign addr_in_c = s0_vld_c ? addr_c : addr_q[0];
  assign cam_in_c  = s0_vld_c ? camera_pixel_in : cam_q[0];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_q <= '0;
      cam_q  <= '0;
      hit_q  <= '0;
      vld_q  <= '0;
    end else begin
      addr_q <= AQ_W'({addr_q, addr_in_c});
      cam_q  <= CQ_W'({cam_q, cam_in_c});
      hit_q  <= BRAM_LAT'({hit_q, s0_vld_c && hit_c});
      vld_q  <= BRAM_LAT'({vld_q, s0_vld_c});
    end
  end

  assign pixel_addr_bram_check_out = addr_q[0];

  // Decide stage: painted-tag protection and mode rules
  logic             painted_c, we_c, bram_unused_c;
  logic [PIX_W-1:0] cam_word_c, color_word_c, wdata_c;

  assign painted_c     = (pixel_from_bram_in[PIX_W-1 -: 2] == 2'b11);
  assign bram_unused_c = ^pixel_from_bram_in[PIX_W-3:0];

  always_comb begin
    we_c         = 1'b0;
    wdata_c      = '0;
    cam_word_c   = PIX_W'(cam_q[BRAM_LAT-1]);
    color_word_c = '0;
    color_word_c[PIX_W-1 -: 2] = 2'b11;
    color_word_c[1:0]          = color_select_in;
    case (mode_in)
      MODE_WRITE: begin
        we_c    = !painted_c;
        wdata_c = hit_q[BRAM_LAT-1] ? color_word_c : cam_word_c;
      end
      MODE_ERASE: begin
        we_c    = !painted_c || hit_q[BRAM_LAT-1];
        wdata_c = cam_word_c;
      end
      MODE_CLEAR: begin
        we_c    = 1'b1;
        wdata_c = cam_word_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_pixel_forbram <= 1'b0;
      pixel_out_forbram   <= '0;
      pixel_addr_forbram  <= '0;
    end else begin
      valid_pixel_forbram <= vld_q[BRAM_LAT-1] && we_c;
      if (vld_q[BRAM_LAT-1] && we_c) begin
        pixel_out_forbram  <= wdata_c;
        pixel_addr_forbram <= addr_q[BRAM_LAT-1];
      end
    end
  end

endmodule

// File: tb/tb_stroke_painter.sv
// Randomised bench for stroke_painter: a per-frame pen model predicts every canvas
// write (or its absence) and the exact cycle it must appear on the write port.
`timescale 1ns/1ps
module tb_stroke_painter;

  localparam int H = 320, V = 240, AW = 17, PW = 8, LAT = 2, MAXR = 3, STALE = 4;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [10:0]   x_com_in = '0;
  logic [9:0]    y_com_in = '0;
  logic          com_valid_in = 1'b0;
  logic [10:0]   hcount_in = '0;
  logic [9:0]    vcount_in = '0;
  logic          pixel_valid_in = 1'b0;
  logic [PW-3:0] camera_pixel_in = '0;
  logic [1:0]    color_select_in = '0;
  logic [1:0]    mode_in = '0;
  logic [1:0]    brush_size_in = '0;
  logic [PW-1:0] pixel_from_bram_in;
  logic [AW-1:0] pixel_addr_bram_check_out;
  logic [PW-1:0] pixel_out_forbram;
  logic [AW-1:0] pixel_addr_forbram;
  logic          valid_pixel_forbram;
  logic          pen_down_out;

  always #5 clk_in = ~clk_in;

  stroke_painter #(
    .H_PIXELS(H), .V_PIXELS(V), .ADDR_W(AW), .PIX_W(PW),
    .BRAM_LAT(LAT), .MAX_RADIUS(MAXR), .STALE_FRAMES(STALE)
  ) u_dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .x_com_in(x_com_in), .y_com_in(y_com_in), .com_valid_in(com_valid_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .pixel_valid_in(pixel_valid_in),
    .camera_pixel_in(camera_pixel_in), .color_select_in(color_select_in),
    .mode_in(mode_in), .brush_size_in(brush_size_in),
    .pixel_from_bram_in(pixel_from_bram_in),
    .pixel_addr_bram_check_out(pixel_addr_bram_check_out),
    .pixel_out_forbram(pixel_out_forbram), .pixel_addr_forbram(pixel_addr_forbram),
    .valid_pixel_forbram(valid_pixel_forbram), .pen_down_out(pen_down_out)
  );

  // Canvas BRAM: one registered read stage after the address register (total LAT=2)
  logic [7:0] canvas [H*V];
  logic [7:0] bram_q = '0;
  always @(posedge clk_in) bram_q <= canvas[pixel_addr_bram_check_out];
  assign pixel_from_bram_in = bram_q;

  int n_vec = 0, n_mis = 0, cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  typedef struct { int cyc; bit we; int addr; int data; } exp_t;
  typedef struct { int x; int y; int b; } com_t;
  exp_t expq[$];
  com_t fs_q[$], mid_q[$];

  // Pen model state
  int m_pend_x, m_pend_y, m_pend_r, m_act_x, m_act_y, m_act_r, m_stale;
  bit m_pend_flag, m_pen;

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  task automatic model_reset();
    m_pend_flag = 0; m_pend_x = 0; m_pend_y = 0; m_pend_r = 0;
    m_act_x = 0; m_act_y = 0; m_act_r = 0; m_stale = STALE; m_pen = 0;
  endtask

  // Write expected for one in-frame pixel under the current mode
  task automatic decide(input int a, input bit hit, input int cam, output bit we, output int data);
    bit painted;
    painted = (canvas[a][7:6] == 2'b11);
    we = 0; data = 0;
    case (int'(mode_in))
      0: if (!painted) begin we = 1; data = hit ? (8'hC0 + int'(color_select_in)) : cam; end
      1: if (!painted || hit) begin we = 1; data = cam; end
      2: begin we = 1; data = cam; end
      default: ;
    endcase
  endtask

  // One cycle of stimulus plus the model's view of it
  task automatic drive(input bit pv, input int h, input int v, input bit cv, input int cx, input int cy, input int cb);
    bit fs, hit, we;
    int cam, data, a;
    exp_t e;
    cam = $urandom_range(0, 63);
    pixel_valid_in = pv; hcount_in = 11'(h); vcount_in = 10'(v); camera_pixel_in = 6'(cam);
    com_valid_in = cv; x_com_in = 11'(cx); y_com_in = 10'(cy); brush_size_in = 2'(cb);
    fs = pv && (h == 0) && (v == 0);
    if (fs) begin
      if (m_pend_flag) begin
        m_act_x = m_pend_x; m_act_y = m_pend_y; m_act_r = m_pend_r;
        m_pend_flag = 0; m_stale = 0; m_pen = 1;
      end else begin
        if (m_stale < STALE) m_stale++;
        if (m_stale == STALE) m_pen = 0;
      end
    end
    if (pv && h < H && v < V) begin
      a   = v * H + h;
      hit = m_pen && iabs(h - m_act_x) <= m_act_r && iabs(v - m_act_y) <= m_act_r;
      decide(a, hit, cam, we, data);
      e.cyc = cyc + 1 + LAT; e.we = we; e.addr = a; e.data = data;
      expq.push_back(e);
    end
    if (cv) begin
      m_pend_x = cx; m_pend_y = cy; m_pend_r = (cb > MAXR) ? MAXR : cb; m_pend_flag = 1;
    end
    @(posedge clk_in); #1;
    if (fs) check("pen_down", pen_down_out, m_pen);
    pixel_valid_in = 0; com_valid_in = 0;
  endtask

  task automatic strobe(input int x, input int y, input int b);
    drive(0, 0, 0, 1, x, y, b);
  endtask

  // Frame start, a 9x9 window around (wx,wy), random pixels (some off-canvas), drain
  task automatic frame(input int wx, input int wy, input int nrand);
    com_t c;
    int k = 0;
    if (fs_q.size() > 0) begin c = fs_q.pop_front(); drive(1, 0, 0, 1, c.x, c.y, c.b); end
    else drive(1, 0, 0, 0, 0, 0, 0);
    for (int dy = -4; dy <= 4; dy++)
      for (int dx = -4; dx <= 4; dx++) begin
        int h = wx + dx, v = wy + dy;
        if (h < 0 || v < 0 || (h == 0 && v == 0)) continue;
        if (mid_q.size() > 0 && (k % 10) == 9) begin
          c = mid_q.pop_front(); drive(1, h, v, 1, c.x, c.y, c.b);
        end else drive(1, h, v, 0, 0, 0, 0);
        k++;
        if ($urandom_range(0, 7) == 0) drive(0, 0, 0, 0, 0, 0, 0);
      end
    for (int i = 0; i < nrand; i++)
      drive(1, $urandom_range(0, H + 9), $urandom_range(1, V + 9), 0, 0, 0, 0);
    repeat (LAT + 3) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Every cycle: the write port must match the scheduled expectation or stay idle
  exp_t me;
  bit mon_en = 0;
  always @(negedge clk_in) if (mon_en) begin
    if (expq.size() > 0 && expq[0].cyc == cyc) begin
      me = expq.pop_front();
      check("we", valid_pixel_forbram, me.we);
      if (me.we) begin
        check("waddr", pixel_addr_forbram, me.addr);
        check("wdata", pixel_out_forbram, me.data);
      end
    end else check("idle_we", valid_pixel_forbram, 0);
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, valid_pixel_forbram, 0);
    check({tag, "_wdata"}, pixel_out_forbram, 0);
    check({tag, "_waddr"}, pixel_addr_forbram, 0);
    check({tag, "_raddr"}, pixel_addr_bram_check_out, 0);
    check({tag, "_pen"}, pen_down_out, 0);
  endtask

  initial begin
    exp_t keep[$];
    int sx, sy;
    for (int i = 0; i < H * V; i++) canvas[i] = 8'h00;
    model_reset();
    rst_in = 1;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 0;
    check_reset_outputs("reset");
    mon_en = 1;

    // Basic write, brush 1 at (10,5), colour 2
    mode_in = 2'b00; color_select_in = 2'd2;
    strobe(10, 5, 1);
    frame(10, 5, 40);
    frame(10, 5, 40);

    // Edge clip at the bottom-left corner, largest brush
    strobe(0, 239, 3);
    frame(0, 239, 20);
    frame(0, 239, 20);

    // Painted protect and erase at address 1610 = (10,5)
    canvas[1610] = 8'hC1;
    strobe(10, 5, 1);
    frame(10, 5, 10);
    mode_in = 2'b01;
    frame(10, 5, 10);
    strobe(50, 50, 1);
    frame(10, 5, 10);
    mode_in = 2'b00;

    // Mid-frame strobes wait for the next frame start; the last one wins
    mid_q.push_back('{100, 100, 2});
    frame(50, 50, 10);
    mid_q.push_back('{100, 100, 2});
    mid_q.push_back('{120, 60, 3});
    frame(100, 100, 10);
    frame(120, 60, 10);

    // Strobe on the frame-start cycle only becomes pending
    fs_q.push_back('{200, 150, 3});
    frame(120, 60, 10);
    frame(200, 150, 10);

    // Pen lift after STALE frames without a strobe, then re-arm
    color_select_in = 2'd3;
    repeat (5) frame(200, 150, 5);
    strobe(30, 30, 2);
    frame(30, 30, 10);

    // Randomised canvas, modes, colours and COMs
    for (int i = 0; i < H * V; i++) canvas[i] = 8'($urandom);
    for (int f = 0; f < 10; f++) begin
      mode_in = 2'($urandom_range(0, 3));
      color_select_in = 2'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        sx = $urandom_range(0, H + 10); sy = $urandom_range(0, V + 10);
        strobe(sx, sy, $urandom_range(0, 3));
      end
      if (m_pend_flag) frame(m_pend_x, m_pend_y, 30);
      else frame(m_act_x, m_act_y, 30);
    end

    // Clear frame then hold frame
    mode_in = 2'b10;
    frame(m_act_x, m_act_y, 300);
    mode_in = 2'b11;
    frame(m_act_x, m_act_y, 100);

    // Reset with pixels in flight: nothing scheduled after the reset edge may appear
    mode_in = 2'b10;
    strobe(30, 30, 2);
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) drive(1, 30 + i, 30, 0, 0, 0, 0);
    rst_in = 1;
    keep.delete();
    foreach (expq[i]) if (expq[i].cyc <= cyc) keep.push_back(expq[i]);
    expq = keep;
    model_reset();
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst_in = 0;
    check_reset_outputs("midreset");
    repeat (LAT + 3) drive(0, 0, 0, 0, 0, 0, 0);

    // After reset the pen is idle: write mode gives camera pixels only
    mode_in = 2'b00;
    frame(30, 30, 10);

    check("drain", expq.size(), 0);
    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/stroke_painter.md
Name: stroke_painter

Overview:
- Parametrised successor to the single-brush compare stage. It sits between the filter/COM path and the canvas BRAM.
- For every incoming pixel it reads the canvas word, decides whether the pixel lies under the pen brush, and writes either a pen colour or the live camera pixel back.
- Adds a run-time brush size, frame-aligned COM update, clear/hold modes and pen-lift timeout.
- Frame size and BRAM read latency are parameters.

Parameters:
- H_PIXELS, 320, canvas width in pixels
- V_PIXELS, 240, canvas height in pixels
- ADDR_W, 17, canvas address width; must satisfy 2^ADDR_W >= H_PIXELS*V_PIXELS
- PIX_W, 8, canvas word width; top 2 bits are the painted tag
- BRAM_LAT, 2, cycles from address out to pixel_from_bram valid (1..4)
- MAX_RADIUS, 3, largest brush half-width
- STALE_FRAMES, 4, frames without com_valid_in before the pen lifts

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- x_com_in  in  11  pen centre x
- y_com_in  in  10  pen centre y
- com_valid_in  in  1  one-cycle strobe: COM fields valid
- hcount_in  in  11  current pixel x
- vcount_in  in  10  current pixel y
- pixel_valid_in  in  1  hcount/vcount/camera_pixel_in valid this cycle
- camera_pixel_in  in  PIX_W-2  live luma for this pixel
- color_select_in  in  2  pen colour index
- mode_in  in  2  00 write, 01 erase, 10 clear, 11 hold
- brush_size_in  in  2  brush half-width r, saturated to MAX_RADIUS
- pixel_from_bram_in  in  PIX_W  canvas read data
- pixel_addr_bram_check_out  out  ADDR_W  canvas read address
- pixel_out_forbram  out  PIX_W  write data
- pixel_addr_forbram  out  ADDR_W  write address
- valid_pixel_forbram  out  1  write enable
- pen_down_out  out  1  brush is active this frame

Behaviour:
- Reset:
  - All outputs are 0.
  - Pipeline valid bits are cleared.
  - No COM is held.
  - Stale counter is STALE_FRAMES.
  - pen_down_out is 0.
- Reset mid-frame:
  - In-flight pixels are discarded; no write is issued for them.
- COM latch:
  - com_valid_in loads the pending registers {x, y, r = min(brush_size_in, MAX_RADIUS)} and sets pending_flag.
  - If a later strobe arrives before frame start, it overwrites pending (last wins).
- Frame start: pixel_valid_in with hcount_in==0 and vcount_in==0.
  - If pending_flag is set: active <= pending, pending_flag cleared, stale counter <= 0, pen_down <= 1.
  - Otherwise the stale counter increments, saturating at STALE_FRAMES. Reaching STALE_FRAMES forces pen_down <= 0.
  - If a com_valid_in arrives on the frame-start cycle itself, it goes to pending; the previous pending value is applied.
- Active COM is constant for a whole frame. A mid-frame strobe never changes the current frame.
- FSM states:
  - IDLE: no COM ever received. Writes still follow the mode rules, with hit=0.
  - TRACK: pen_down=1.
  - LIFTED: stale timeout reached.
  - Transitions: IDLE/LIFTED -> TRACK on a frame start with pending. TRACK -> LIFTED on timeout.
- Stage 0 (cycle of pixel_valid_in):
  - Pixels with hcount_in >= H_PIXELS or vcount_in >= V_PIXELS are dropped; no valid is generated.
  - Otherwise pixel_addr_bram_check_out <= vcount_in*H_PIXELS + hcount_in.
  - hit <= pen_down & |hcount_in-x| <= r & |vcount_in-y| <= r, using unsigned absolute difference on 12-bit widened operands.
  - Square brush. Edges clip naturally; no sentinel addresses. r=0 gives a single pixel.
- Alignment: address, hit, camera pixel and valid are delayed BRAM_LAT cycles to line up with pixel_from_bram_in.
- Decide stage (registered): painted = pixel_from_bram_in[PIX_W-1:PIX_W-2]==2'b11. CAM = {2'b00, camera pixel}. COLOR = {2'b11, zeros, color_select_in}.
  - write: hit & !painted -> COLOR. !hit & !painted -> CAM. painted -> no write.
  - erase: painted & hit -> CAM. !painted -> CAM. painted & !hit -> no write.
  - clear: CAM always, regardless of tag or hit.
  - hold: no write ever.
- Mode and colour are sampled at the decide stage.
- Latency: pixel_valid_in to valid_pixel_forbram is BRAM_LAT+1 cycles.
- Throughput: one pixel per cycle; back-to-back valid pixels are supported.
- Write address equals the delayed read address.

Test Plan:
- Basic write:
  - Stimulus: reset, COM (10,5), brush 1, write mode, colour 2, full frame twice, BRAM model returns 0x00.
  - Required: in frame 2, addresses 4*320+9..11, 5*320+9..11 and 6*320+9..11 are written 0xC2; all other in-frame pixels are written CAM; latency BRAM_LAT+1.
- Edge clip:
  - Stimulus: COM (0,239), brush 3.
  - Required: writes only at x 0..3, y 236..239; no address >= 76800 is ever issued.
- Painted protect and erase:
  - Stimulus: BRAM returns 0xC1 at address 1610, COM (10,5).
  - Required: write mode gives no write at 1610; erase mode writes CAM at 1610; erase at COM (50,50) gives no write at 1610.
- Frame alignment:
  - Stimulus: com_valid_in mid-frame with (100,100).
  - Required: brush stays at the old COM until the next (0,0); two strobes in one frame -> only the last is applied.
- Pen lift:
  - Stimulus: no com_valid_in for 4 frames.
  - Required: pen_down_out falls at the 4th frame start; no COLOR writes afterwards; a new strobe re-arms at the next frame start.
- Modes and reset:
  - Stimulus: clear mode for one frame; hold mode for one frame; rst_in asserted mid-pipeline.
  - Required: clear writes all 76800 pixels with CAM; hold gives valid_pixel_forbram=0 throughout; after reset, outputs are 0 and no stale write emerges.
